// File: rtl/gate_pipe_if.sv
// rtl/gate_pipe_if.sv - operand/result handshake bundle for gate_pipe (parity port when GATE_PIPE_PARITY_EN)
interface gate_pipe_if #(
    parameter int WIDTH = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] acc;
`ifdef GATE_PIPE_PARITY_EN
    logic             parity;
`endif

`ifdef GATE_PIPE_PARITY_EN
    modport master (
        output in_valid, a, b, op, acc_clr, out_ready,
        input  in_ready, out_valid, z, acc, parity
    );
    modport slave (
        input  in_valid, a, b, op, acc_clr, out_ready,
        output in_ready, out_valid, z, acc, parity
    );
`else
    modport master (
        output in_valid, a, b, op, acc_clr, out_ready,
        input  in_ready, out_valid, z, acc
    );
    modport slave (
        input  in_valid, a, b, op, acc_clr, out_ready,
        output in_ready, out_valid, z, acc
    );
`endif
endinterface

// File: rtl/gate_pipe.sv
// rtl/gate_pipe.sv - pipelined bitwise logic unit with accumulator; optional z parity via GATE_PIPE_PARITY_EN
module gate_pipe #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    gate_pipe_if.slave   bus
);
    logic              advance;
    logic              accept;
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  data [STAGES];
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_next;
    logic [WIDTH-1:0]  res;

    // Whole pipe moves as one; it only stalls when the last stage is held.
    assign advance      = !vld[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = vld[STAGES-1];
    assign bus.z         = data[STAGES-1];
    assign bus.acc       = acc_q;

    // Stage-1 result; op 7 folds a^b into the pre-update accumulator (or zero on clear).
    always_comb begin
        acc_next = (bus.acc_clr ? '0 : acc_q) ^ bus.a ^ bus.b;
        res      = '0;
        case (bus.op)
            3'd0:    res = bus.a & bus.b;
            3'd1:    res = bus.a | bus.b;
            3'd2:    res = bus.a ^ bus.b;
            3'd3:    res = ~(bus.a & bus.b);
            3'd4:    res = ~(bus.a | bus.b);
            3'd5:    res = ~(bus.a ^ bus.b);
            3'd6:    res = ~bus.a;
            default: res = acc_next;
        endcase
    end

    // Pipeline registers: per-stage valid plus data, shifted together on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= '0;
            end
        end else if (advance) begin
            vld[0] <= accept;
            if (accept) begin
                data[0] <= res;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld[i]  <= vld[i-1];
                data[i] <= data[i-1];
            end
        end
    end

    // Accumulator changes only on an accepted transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept) begin
            if (bus.op == 3'd7) begin
                acc_q <= acc_next;
            end else if (bus.acc_clr) begin
                acc_q <= '0;
            end
        end
    end

`ifdef GATE_PIPE_PARITY_EN
    logic [STAGES-1:0] par;

    assign bus.parity = par[STAGES-1];

    // Parity travels with its result so it stays aligned with z through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            par <= '0;
        end else if (advance) begin
            if (accept) begin
                par[0] <= ^res;
            end
            for (int i = 1; i < STAGES; i++) begin
                par[i] <= par[i-1];
            end
        end
    end
`endif
endmodule

// File: tb/tb_gate_pipe.sv
// tb/tb_gate_pipe.sv - scoreboard bench for gate_pipe
module tb_gate_pipe;
    localparam int W = 5;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gate_pipe_if #(.WIDTH(W)) bus ();

    gate_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q [$];
    int           out_cyc [$];
    logic [W-1:0] m_acc;
    logic [W-1:0] mon_e;
    logic [W-1:0] held_z;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("z", bus.z, mon_e);
`ifdef GATE_PIPE_PARITY_EN
                chk("parity", bus.parity, ^mon_e);
`endif
                out_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic clr);
        bit done;
        logic [W-1:0] t;
        logic [W-1:0] r;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = a;
            bus.b        = b;
            bus.op       = op;
            bus.acc_clr  = clr;
            #1;
            if (bus.in_ready) begin
                t = (clr ? '0 : m_acc) ^ a ^ b;
                case (op)
                    3'd0: r = a & b;
                    3'd1: r = a | b;
                    3'd2: r = a ^ b;
                    3'd3: r = ~(a & b);
                    3'd4: r = ~(a | b);
                    3'd5: r = ~(a ^ b);
                    3'd6: r = ~a;
                    default: r = t;
                endcase
                if (op == 3'd7) m_acc = t;
                else if (clr)   m_acc = '0;
                exp_q.push_back(r);
                done = 1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 0, 1);
        else       chk("acc", bus.acc, m_acc);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_acc         = '0;
        bus.in_valid  = 1'b1;
        bus.a         = 5'h1F;
        bus.b         = 5'h01;
        bus.op        = 3'd7;
        bus.acc_clr   = 1'b1;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_z", bus.z, 0);
        chk("rst_acc", bus.acc, 0);
`ifdef GATE_PIPE_PARITY_EN
        chk("rst_parity", bus.parity, 0);
`endif
        bus.in_valid = 1'b0;
        rst = 1'b0;
        idle(2);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_acc", bus.acc, 0);

        // Single XOR, latency check
        send(5'h15, 5'h0F, 3'd2, 1'b0);
        bus.in_valid = 1'b0;
        chk("lat1_out_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("lat2_out_valid", bus.out_valid, 1);
        chk("lat2_z", bus.z, 5'h1A);
`ifdef GATE_PIPE_PARITY_EN
        chk("par_1a", bus.parity, 1);
`endif
        idle(3);

        // Back-to-back ops 0..6
        out_cyc.delete();
        for (int i = 0; i < 7; i++) send(5'h1C, 5'h0A, 3'(i), 1'b0);
        idle(4);
        chk("b2b_count", out_cyc.size(), 7);
        if (out_cyc.size() == 7)
            for (int i = 1; i < 7; i++) chk("b2b_consec", out_cyc[i] - out_cyc[i-1], 1);

        // Downstream stall
        bus.out_ready = 1'b0;
        send(5'h13, 5'h0E, 3'd0, 1'b0);
        send(5'h03, 5'h04, 3'd1, 1'b0);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_z", bus.z, 5'h02);
        held_z = bus.z;
        bus.in_valid = 1'b1;
        bus.a = 5'h11; bus.b = 5'h06; bus.op = 3'd2; bus.acc_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready_hold", bus.in_ready, 0);
            chk("stall_out_valid_hold", bus.out_valid, 1);
            chk("stall_z_hold", bus.z, held_z);
        end
        bus.out_ready = 1'b1;
        send(5'h11, 5'h06, 3'd2, 1'b0);
        idle(4);
        chk("stall_drained", exp_q.size(), 0);

        // Accumulator clear then accumulate
        send(5'h03, 5'h00, 3'd7, 1'b1);
        send(5'h05, 5'h01, 3'd7, 1'b0);
        chk("acc_07", bus.acc, 5'h07);
        idle(4);

        // acc_clr with a non-acc op zeroes the accumulator
        send(5'h04, 5'h02, 3'd0, 1'b1);
        chk("acc_clr_nonacc", bus.acc, 5'h00);
        idle(4);

        // Reset with transactions in flight
        send(5'h0A, 5'h05, 3'd7, 1'b0);
        send(5'h01, 5'h02, 3'd1, 1'b0);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        m_acc = '0;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_acc", bus.acc, 0);
        chk("mid_rst_z", bus.z, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        idle(5);
        send(5'h1C, 5'h0A, 3'd7, 1'b0);
        idle(4);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gate_pipe.md
GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 5: operand and result width in bits (1..64).
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth in register stages (1..4).
REQ-003 SHALL provide port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port in_valid, input, 1 bit: an input transaction is offered.
REQ-006 SHALL provide port in_ready, output, 1 bit: the block accepts a transaction this cycle.
REQ-007 SHALL provide port a, input, WIDTH bits: operand A.
REQ-008 SHALL provide port b, input, WIDTH bits: operand B.
REQ-009 SHALL provide port op, input, 3 bits: operation select.
REQ-010 SHALL provide port acc_clr, input, 1 bit: clear the accumulator on accept.
REQ-011 SHALL provide port out_valid, output, 1 bit: z is valid.
REQ-012 SHALL provide port out_ready, input, 1 bit: downstream takes z this cycle.
REQ-013 SHALL provide port z, output, WIDTH bits: result.
REQ-014 SHALL provide port acc, output, WIDTH bits: current accumulator value.

Function
REQ-015 SHALL accept a transaction when in_valid && in_ready; SHALL complete output handshake when out_valid && out_ready.
REQ-016 SHALL compute op encodings: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a (b ignored), 7 ACC (z = acc ^ a ^ b).
REQ-017 SHALL drive advance = !out_valid || out_ready; all stages shift together on advance; in_ready = advance.
REQ-018 SHALL present an accepted result on z with out_valid high exactly STAGES cycles after accept when out_ready is held high.
REQ-019 SHALL hold z and out_valid stable while out_valid && !out_ready; no transaction lost or duplicated.
REQ-020 SHALL carry a per-stage valid bit; empty stages (bubbles) never raise out_valid.
REQ-021 SHALL sustain one transaction per cycle with in_valid and out_ready both high.
REQ-022 SHALL update acc on the accept cycle for op 7 only: acc <= acc ^ a ^ b; acc visible the following cycle.
REQ-023 SHALL on accept with acc_clr=1 and op!=7 set acc <= 0; with acc_clr=1 and op=7 set acc <= a ^ b and z = a ^ b.
REQ-024 SHALL ignore acc_clr when no transaction is accepted.
REQ-025 SHALL compute the stage-1 result from the pre-update acc value for op 7 (acc_clr=0).
REQ-026 SHALL truncate nothing: all ops bitwise on WIDTH bits, no carries.

Reset
REQ-027 SHALL on rst=1 at a clock edge clear all stage valid bits, z to 0, acc to 0, out_valid to 0.
REQ-028 SHALL hold in_ready at 0 during any cycle with rst=1; transactions offered then are dropped.
REQ-029 SHALL discard in-flight transactions when rst asserts mid-operation; first accept after rst deassert behaves as from power-up.

Configuration
REQ-030 SHALL, when macro GATE_PIPE_PARITY_EN is defined, add output port parity (1 bit) = XOR-reduce of z, registered alongside z, reset to 0, stable under stall.
REQ-031 SHALL, when GATE_PIPE_PARITY_EN is undefined, omit the parity port and its logic; all other behaviour is identical.

Verification (WIDTH=5, STAGES=2)
REQ-032 SHALL check: op=2, a=5'h15, b=5'h0F, out_ready=1 -> z=5'h1A, out_valid high 2 cycles after accept.
REQ-033 SHALL check: back-to-back ops 0..6 with a=5'h1C, b=5'h0A -> z sequence 08,1E,16,17,01,09,03 on consecutive cycles.
REQ-034 SHALL check: out_ready=0 for 5 cycles with 3 accepts attempted -> in_ready drops once pipe full, z held; on release all 3 results emerge in order.
REQ-035 SHALL check: op=7 with acc_clr=1, a=5'h03, b=5'h00, then op=7 a=5'h05 b=5'h01 -> z=03 then 07, acc=07.
REQ-036 SHALL check: rst pulsed with 2 transactions in flight -> out_valid=0, acc=0, z=0 next cycle, no stale result emerges.
REQ-037 SHALL check (GATE_PIPE_PARITY_EN defined): z=5'h1A -> parity=1; z=5'h03 -> parity=0.
